os_psum_collector: RTL and testbench

// Receiving end of the MAC array's output path. Captures partial sums driven by the array

---
 rtl/os_psum_collector.sv | 94 +++++++++
 tb/tb_os_psum_collector.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/os_psum_collector.sv
// os_psum_collector: per-column circular queues that realign skewed MAC-array
// psum columns into one vector for the psum SRAM write side.
module os_psum_collector #(
    parameter int unsigned col     = 8,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned depth   = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [col*psum_bw-1:0]   in,
    input  logic [col-1:0]           wr,
    input  logic                     rd,
    output logic [col*psum_bw-1:0]   out,
    output logic                     o_valid,
    output logic                     o_full,
    output logic                     o_ready,
    output logic                     o_overflow,
    output logic                     o_rd_ack
);

    localparam int unsigned AW = $clog2(depth);

    logic [psum_bw-1:0] mem  [col][depth];
    logic [AW:0]        wptr [col];
    logic [AW:0]        rptr [col];
    logic [col-1:0]     empty;
    logic [col-1:0]     full;
    logic               pop;

    // Per-column empty/full from the extra-MSB pointer pair
    always_comb begin
        empty = '0;
        full  = '0;
        for (int unsigned c = 0; c < col; c++) begin
            empty[c] = (wptr[c] == rptr[c]);
            full[c]  = (wptr[c][AW] != rptr[c][AW]) &&
                       (wptr[c][AW-1:0] == rptr[c][AW-1:0]);
        end
    end

    assign o_valid = &(~empty);
    assign o_full  = |full;
    assign o_ready = ~o_full;
    assign pop     = rd && o_valid;

    // Queue storage; writes to a full column are dropped, contents need no reset
    always_ff @(posedge clk) begin
        for (int unsigned c = 0; c < col; c++) begin
            if (wr[c] && !full[c]) begin
                mem[c][wptr[c][AW-1:0]] <= in[psum_bw*c +: psum_bw];
            end
        end
    end

    // Write pointers and sticky overflow flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned c = 0; c < col; c++) begin
                wptr[c] <= '0;
            end
            o_overflow <= 1'b0;
        end else begin
            for (int unsigned c = 0; c < col; c++) begin
                if (wr[c]) begin
                    if (full[c]) begin
                        o_overflow <= 1'b1;
                    end else begin
                        wptr[c] <= wptr[c] + (AW+1)'(1);
                    end
                end
            end
        end
    end

    // Aligned pop: every column advances together, out is registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned c = 0; c < col; c++) begin
                rptr[c] <= '0;
            end
            out      <= '0;
            o_rd_ack <= 1'b0;
        end else begin
            o_rd_ack <= pop;
            if (pop) begin
                for (int unsigned c = 0; c < col; c++) begin
                    out[psum_bw*c +: psum_bw] <= mem[c][rptr[c][AW-1:0]];
                    rptr[c] <= rptr[c] + (AW+1)'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_os_psum_collector.sv
// Self-checking bench for os_psum_collector against a queue-based reference model.
module tb_os_psum_collector;

    localparam int unsigned COL   = 8;
    localparam int unsigned BW    = 16;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned VW    = COL*BW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [VW-1:0] in = '0;
    logic [COL-1:0] wr = '0;
    logic          rd = 1'b0;
    logic [VW-1:0] out;
    logic          o_valid, o_full, o_ready, o_overflow, o_rd_ack;

    int checks = 0;
    int errors = 0;

    // Reference model: one plain queue per column plus registered outputs
    logic [BW-1:0] q [COL][$];
    logic [VW-1:0] m_out = '0;
    logic          m_ack = 1'b0;
    logic          m_ovf = 1'b0;

    os_psum_collector #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
        .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd), .out(out),
        .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready),
        .o_overflow(o_overflow), .o_rd_ack(o_rd_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic m_valid();
        for (int c = 0; c < COL; c++) if (q[c].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_full();
        for (int c = 0; c < COL; c++) if (q[c].size() == DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < VW/32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic m_reset();
        for (int c = 0; c < COL; c++) q[c].delete();
        m_out = '0;
        m_ack = 1'b0;
        m_ovf = 1'b0;
    endtask

    // One clock: drive inputs, advance the model using pre-edge occupancy
    task automatic cycle(input logic [COL-1:0] w, input logic [VW-1:0] d, input logic r);
        logic           p;
        logic [COL-1:0] drop;
        wr = w; in = d; rd = r;
        p = r && m_valid();
        for (int c = 0; c < COL; c++) drop[c] = w[c] && (q[c].size() == DEPTH);
        @(posedge clk); #1;
        if (p) for (int c = 0; c < COL; c++) m_out[BW*c +: BW] = q[c].pop_front();
        m_ack = p;
        for (int c = 0; c < COL; c++) begin
            if (w[c]) begin
                if (drop[c]) m_ovf = 1'b1;
                else q[c].push_back(d[BW*c +: BW]);
            end
        end
        wr = '0; rd = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        m_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out !== '0) begin errors++; $display("FAIL reset_out: got %h want 0", out); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", o_full); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_ready); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", o_overflow); end
        checks++; if (o_rd_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", o_rd_ack); end
    endtask

    task automatic test_single();
        logic [VW-1:0] d, want;
        want = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
        for (int c = 0; c < COL; c++) d[BW*c +: BW] = BW'(c + 1);
        cycle(8'hFF, d, 1'b0);
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", o_valid); end
        cycle('0, '0, 1'b1);
        checks++; if (out !== want) begin errors++; $display("FAIL single_out: got %h want %h", out, want); end
        checks++; if (o_rd_ack !== 1'b1) begin errors++; $display("FAIL single_ack: got %b want 1", o_rd_ack); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL single_valid_after: got %b want 0", o_valid); end
        cycle('0, '0, 1'b0);
        checks++; if (o_rd_ack !== 1'b0) begin errors++; $display("FAIL single_ack_drop: got %b want 0", o_rd_ack); end
    endtask

    task automatic test_skew();
        for (int k = 0; k < COL; k++) begin
            cycle(COL'(1) << k, rand_vec(), 1'b0);
            if (k < COL-1) begin
                checks++;
                if (o_valid !== 1'b0) begin errors++; $display("FAIL skew_valid_early k=%0d: got %b want 0", k, o_valid); end
            end
        end
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL skew_valid: got %b want 1", o_valid); end
        cycle('0, '0, 1'b1);
        checks++; if (out !== m_out) begin errors++; $display("FAIL skew_out: got %h want %h", out, m_out); end
        checks++; if (o_rd_ack !== 1'b1) begin errors++; $display("FAIL skew_ack: got %b want 1", o_rd_ack); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(8'hFF, rand_vec(), 1'b0);
        checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", o_full); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL fill_ready: got %b want 0", o_ready); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf_early: got %b want 0", o_overflow); end
        cycle(8'hFF, rand_vec(), 1'b0);
        checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL fill_ovf: got %b want 1", o_overflow); end
        for (int i = 0; i < DEPTH; i++) begin
            cycle('0, '0, 1'b1);
            checks++; if (out !== m_out) begin errors++; $display("FAIL fill_pop%0d: got %h want %h", i, out, m_out); end
        end
        checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL fill_ovf_sticky: got %b want 1", o_overflow); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL fill_drained: got %b want 0", o_valid); end
        checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL fill_unfull: got %b want 0", o_full); end
    endtask

    task automatic test_wrap();
        logic saw_full;
        saw_full = 1'b0;
        do_reset();
        for (int i = 0; i < 40; i++) begin cycle(8'hFF, rand_vec(), 1'b0); saw_full |= o_full; end
        for (int i = 0; i < 40; i++) begin
            cycle('0, '0, 1'b1);
            checks++; if (out !== m_out) begin errors++; $display("FAIL wrap_pop%0d: got %h want %h", i, out, m_out); end
        end
        for (int i = 0; i < 40; i++) begin cycle(8'hFF, rand_vec(), 1'b0); saw_full |= o_full; end
        checks++; if (saw_full !== 1'b0) begin errors++; $display("FAIL wrap_full: got %b want 0", saw_full); end
        for (int i = 0; i < 40; i++) begin
            cycle('0, '0, 1'b1);
            checks++; if (out !== m_out) begin errors++; $display("FAIL wrap_pop2_%0d: got %h want %h", i, out, m_out); end
        end
    endtask

    task automatic test_rd_empty();
        logic [VW-1:0] held;
        do_reset();
        cycle(8'hFF, rand_vec(), 1'b0);
        cycle('0, '0, 1'b1);
        held = m_out;
        for (int i = 0; i < 5; i++) cycle(8'hF7, rand_vec(), 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle('0, '0, 1'b1);
            checks++; if (o_rd_ack !== 1'b0) begin errors++; $display("FAIL rdempty_ack%0d: got %b want 0", i, o_rd_ack); end
            checks++; if (out !== held) begin errors++; $display("FAIL rdempty_out%0d: got %h want %h", i, out, held); end
        end
        cycle(8'h08, rand_vec(), 1'b1);
        checks++; if (o_rd_ack !== 1'b0) begin errors++; $display("FAIL rdempty_bypass: got %b want 0", o_rd_ack); end
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL rdempty_valid: got %b want 1", o_valid); end
        cycle('0, '0, 1'b1);
        checks++; if (o_rd_ack !== 1'b1) begin errors++; $display("FAIL rdempty_pop_ack: got %b want 1", o_rd_ack); end
        checks++; if (out !== m_out) begin errors++; $display("FAIL rdempty_pop_out: got %h want %h", out, m_out); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 11; i++) cycle(8'hFF, rand_vec(), 1'b0);
        cycle('0, '0, 1'b1);
        reset = 1'b0;
        m_reset();
        #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", o_valid); end
        checks++; if (out !== '0) begin errors++; $display("FAIL mid_out: got %h want 0", out); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_valid_rel: got %b want 0", o_valid); end
        cycle(8'hFF, rand_vec(), 1'b0);
        cycle('0, '0, 1'b1);
        checks++; if (out !== m_out) begin errors++; $display("FAIL mid_roundtrip: got %h want %h", out, m_out); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_empty: got %b want 0", o_valid); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic r;
            r = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cycle(COL'($urandom_range(0, 255)), rand_vec(), r);
            checks++; if (out !== m_out) begin errors++; $display("FAIL rnd_out%0d: got %h want %h", i, out, m_out); end
            checks++; if (o_rd_ack !== m_ack) begin errors++; $display("FAIL rnd_ack%0d: got %b want %b", i, o_rd_ack, m_ack); end
            checks++; if (o_valid !== m_valid()) begin errors++; $display("FAIL rnd_valid%0d: got %b want %b", i, o_valid, m_valid()); end
            checks++; if (o_full !== m_full()) begin errors++; $display("FAIL rnd_full%0d: got %b want %b", i, o_full, m_full()); end
            checks++; if (o_ready !== !m_full()) begin errors++; $display("FAIL rnd_ready%0d: got %b want %b", i, o_ready, !m_full()); end
            checks++; if (o_overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf%0d: got %b want %b", i, o_overflow, m_ovf); end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_single();
        test_skew();
        test_fill();
        test_wrap();
        test_rd_empty();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
